// File: rtl/leds_racer_pkg.sv
// leds_racer_pkg: colour constants, default 50 MHz WS2812 timing and serializer types
package leds_racer_pkg;
    localparam int GRB_W = 24;
    localparam logic [GRB_W-1:0] BLUE   = 24'h0000FF;
    localparam logic [GRB_W-1:0] RED    = 24'h00FF00;
    localparam logic [GRB_W-1:0] GREEN  = 24'hFF0000;
    localparam logic [GRB_W-1:0] YELLOW = 24'hFFFF00;
    localparam logic [GRB_W-1:0] OFF    = 24'h000000;
    localparam int DEF_NUM_LEDS     = 109;
    localparam int DEF_T0H_CYCLES   = 20;
    localparam int DEF_T1H_CYCLES   = 40;
    localparam int DEF_TBIT_CYCLES  = 63;
    localparam int DEF_RESET_CYCLES = 15000;
    typedef enum logic [1:0] {IDLE, FETCH, SEND, LATCH} state_t;
    function automatic int max2(int a, int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/ws2812_frame_serializer_if.sv
// ws2812_frame_serializer_if: game-core to serializer frame handshake and strip output
interface ws2812_frame_serializer_if
    import leds_racer_pkg::*;
#(
    parameter int IDX_W = 7
);
    logic             start;
    logic [GRB_W-1:0] color_grb;
    logic [IDX_W-1:0] led_index;
    logic             busy;
    logic             done;
    logic             leds_line;
    modport master (output start, color_grb, input led_index, busy, done, leds_line);
    modport slave  (input start, color_grb, output led_index, busy, done, leds_line);
endinterface

// File: rtl/ws2812_frame_serializer_bit_encoder.sv
// ws2812_bit_encoder: pulse-width timing of one bit, or of the low latch gap, on a registered line
module ws2812_bit_encoder
    import leds_racer_pkg::*;
#(
    parameter int T0H_CYCLES   = DEF_T0H_CYCLES,
    parameter int T1H_CYCLES   = DEF_T1H_CYCLES,
    parameter int TBIT_CYCLES  = DEF_TBIT_CYCLES,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic bit_start,
    input  logic bit_val,
    input  logic gap_start,
    output logic line,
    output logic bit_last
);
    localparam int CW = $clog2(max2(TBIT_CYCLES, RESET_CYCLES));
    logic [CW-1:0] cnt_q, cnt_d, thr_q, thr_d;
    logic          act_q, act_d, gap_q, gap_d, line_q;
    assign bit_last = act_q && cnt_q == (gap_q ? CW'(RESET_CYCLES - 1) : CW'(TBIT_CYCLES - 1));
    assign line = line_q;
    // the gap is a period whose high threshold is zero
    always_comb begin
        cnt_d = (bit_start || gap_start || bit_last) ? '0 : act_q ? cnt_q + 1'b1 : cnt_q;
        act_d = bit_start || gap_start || (act_q && !bit_last);
        gap_d = (bit_start || gap_start) ? gap_start : gap_q;
        thr_d = bit_start ? (bit_val ? CW'(T1H_CYCLES) : CW'(T0H_CYCLES)) : gap_start ? '0 : thr_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            thr_q  <= '0;
            act_q  <= 1'b0;
            gap_q  <= 1'b0;
            line_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            thr_q  <= thr_d;
            act_q  <= act_d;
            gap_q  <= gap_d;
            line_q <= act_d && cnt_d < thr_d;
        end
    end
endmodule

// File: rtl/ws2812_frame_serializer.sv
// ws2812_frame_serializer: walks the strip once per start, serialising each GRB colour, then latches
module ws2812_frame_serializer
    import leds_racer_pkg::*;
#(
    parameter int NUM_LEDS     = DEF_NUM_LEDS,
    parameter int T0H_CYCLES   = DEF_T0H_CYCLES,
    parameter int T1H_CYCLES   = DEF_T1H_CYCLES,
    parameter int TBIT_CYCLES  = DEF_TBIT_CYCLES,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int IDX_W        = NUM_LEDS > 1 ? $clog2(NUM_LEDS) : 1
) (
    input logic clk,
    input logic reset,
    ws2812_frame_serializer_if.slave bus
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);
    state_t           state_q, state_d;
    logic [GRB_W-2:0] sreg_q, sreg_d;
    logic [4:0]       bitn_q, bitn_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             last_q, last_d, done_q, done_d;
    logic             line, bit_last, bit_start, bit_val, gap_start, load, led_end;

    ws2812_bit_encoder #(
        .T0H_CYCLES  (T0H_CYCLES),
        .T1H_CYCLES  (T1H_CYCLES),
        .TBIT_CYCLES (TBIT_CYCLES),
        .RESET_CYCLES(RESET_CYCLES)
    ) u_enc (
        .clk      (clk),
        .reset    (reset),
        .bit_start(bit_start),
        .bit_val  (bit_val),
        .gap_start(gap_start),
        .line     (line),
        .bit_last (bit_last)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // a start landing on the done cycle is dropped, so back-to-back frames leave one idle cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.start && !done_q ? FETCH : IDLE;
            FETCH:   state_d = SEND;
            SEND:    state_d = gap_start ? LATCH : SEND;
            LATCH:   state_d = bit_last ? IDLE : LATCH;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        led_end   = state_q == SEND && bit_last && bitn_q == 5'd23;
        load      = state_q == FETCH || (led_end && !last_q);
        gap_start = led_end && last_q;
        bit_start = load || (state_q == SEND && bit_last && !led_end);
        bit_val   = load ? bus.color_grb[GRB_W-1] : sreg_q[GRB_W-2];
        sreg_d    = load ? bus.color_grb[GRB_W-2:0] : bit_start ? {sreg_q[GRB_W-3:0], 1'b0} : sreg_q;
        bitn_d    = load ? '0 : bit_start ? bitn_q + 1'b1 : bitn_q;
        // prefetch the next colour as soon as the current LED starts; saturate on the last one
        idx_d     = (state_q == LATCH && bit_last) ? '0 : (load && idx_q != LAST_IDX) ? idx_q + 1'b1 : idx_q;
        last_d    = load ? idx_q == LAST_IDX : last_q;
        done_d    = state_q == LATCH && bit_last;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sreg_q <= '0;
            bitn_q <= '0;
            idx_q  <= '0;
            last_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            sreg_q <= sreg_d;
            bitn_q <= bitn_d;
            idx_q  <= idx_d;
            last_q <= last_d;
            done_q <= done_d;
        end
    end

    assign bus.led_index = idx_q;
    assign bus.busy      = state_q != IDLE;
    assign bus.done      = done_q;
    assign bus.leds_line = line;
endmodule

// File: tb/tb_ws2812_frame_serializer.sv
// tb_ws2812_frame_serializer: directed vectors and frame-level model checks on a 3-LED strip
module tb_ws2812_frame_serializer;
    localparam int N = 3, T0 = 2, T1 = 4, TB = 6, RC = 10;
    localparam int LED_CYC = 24 * TB;
    localparam int SEND_END = 1 + N * LED_CYC;
    localparam int DONE_N = SEND_END + RC + 1;
    localparam int FL = DONE_N + 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ws2812_frame_serializer_if #(.IDX_W(2)) bus();
    logic [23:0] tbl [4];
    always @(posedge clk) bus.color_grb <= tbl[bus.led_index];

    ws2812_frame_serializer #(
        .NUM_LEDS(N), .T0H_CYCLES(T0), .T1H_CYCLES(T1), .TBIT_CYCLES(TB), .RESET_CYCLES(RC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0, failures = 0;
    logic       cl [1:900], cb [1:900], cd [1:900];
    logic [1:0] ci [1:900];
    string sn [4] = '{"line", "busy", "done", "idx"};

    typedef struct {int n; logic line; logic busy; logic done; int idx;} vec_t;
    vec_t vecs [18];
    int hs_n [7], hs_v [7];

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // sample j is the value seen in the cycle ending at edge k+j, k being the edge that samples start
    task automatic cap(int len, int s1, int s2, bit hold, int rst_at);
        @(negedge clk);
        bus.start = 1'b1;
        for (int j = 1; j <= len; j++) begin
            @(negedge clk);
            cl[j] = bus.leds_line;
            cb[j] = bus.busy;
            cd[j] = bus.done;
            ci[j] = bus.led_index;
            bus.start = hold || j == s1 || j == s2;
            reset = j == rst_at;
        end
        bus.start = 1'b0;
        reset = 1'b0;
    endtask

    function automatic int got(int s, int j);
        return s == 0 ? int'(cl[j]) : s == 1 ? int'(cb[j]) : s == 2 ? int'(cd[j]) : int'(ci[j]);
    endfunction

    function automatic int want(int s, int jj);
        int t, v, n;
        if (s == 1) return int'(jj >= 1 && jj < DONE_N);
        if (s == 2) return int'(jj == DONE_N);
        if (s == 3) begin
            if (jj < 2 || jj >= DONE_N) return 0;
            n = (jj - 2) / LED_CYC + 1;
            return n > N - 1 ? N - 1 : n;
        end
        if (jj < 2 || jj > SEND_END) return 0;
        t = jj - 2;
        v = int'(tbl[t / LED_CYC][23 - (t % LED_CYC) / TB]);
        return int'((t % TB) < (v != 0 ? T1 : T0));
    endfunction

    task automatic cmp_model(string nm, int from, int to);
        for (int s = 0; s < 4; s++) begin
            int bad = 0, fj = 0;
            for (int j = from; j <= to; j++)
                if (got(s, j) != want(s, j % FL)) begin
                    if (bad == 0) fj = j;
                    bad++;
                end
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL %s_%s: %0d cycles differ, first at k+%0d got %0d expected %0d",
                         nm, sn[s], bad, fj, got(s, fj), want(s, fj % FL));
            end
        end
    endtask

    initial begin
        int cnt;
        vecs = '{'{1, 0, 1, 0, 0}, '{2, 1, 1, 0, 1}, '{5, 1, 1, 0, 1}, '{6, 0, 1, 0, 1},
                 '{8, 1, 1, 0, 1}, '{50, 1, 1, 0, 1}, '{52, 0, 1, 0, 1}, '{146, 1, 1, 0, 2},
                 '{148, 0, 1, 0, 2}, '{386, 1, 1, 0, 2}, '{389, 1, 1, 0, 2}, '{390, 0, 1, 0, 2},
                 '{431, 1, 1, 0, 2}, '{432, 0, 1, 0, 2}, '{434, 0, 1, 0, 2}, '{443, 0, 1, 0, 2},
                 '{444, 0, 0, 1, 0}, '{445, 0, 0, 0, 0}};
        hs_n = '{140, 143, 144, 145, 146, 149, 150};
        hs_v = '{1, 1, 0, 0, 1, 1, 0};
        tbl = '{24'hFF0000, 24'h000000, 24'h0000FF, 24'h000000};
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_line", int'(bus.leds_line), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_idx", int'(bus.led_index), 0);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            cnt += int'(bus.busy) + int'(bus.leds_line) + int'(bus.done);
        end
        chk("idle_quiet", cnt, 0);

        cap(446, 0, 0, 1'b0, 0);
        for (int i = 0; i < 18; i++) begin
            chk($sformatf("vec%0d_line", vecs[i].n), got(0, vecs[i].n), int'(vecs[i].line));
            chk($sformatf("vec%0d_busy", vecs[i].n), got(1, vecs[i].n), int'(vecs[i].busy));
            chk($sformatf("vec%0d_done", vecs[i].n), got(2, vecs[i].n), int'(vecs[i].done));
            chk($sformatf("vec%0d_idx", vecs[i].n), got(3, vecs[i].n), vecs[i].idx);
        end
        cmp_model("frame1", 1, 445);

        @(negedge clk);
        tbl = '{24'h000001, 24'h800000, 24'h000000, 24'h000000};
        cap(446, 0, 0, 1'b0, 0);
        for (int i = 0; i < 7; i++) chk($sformatf("seam_k+%0d", hs_n[i]), got(0, hs_n[i]), hs_v[i]);
        cmp_model("seam", 1, 445);

        @(negedge clk);
        tbl = '{24'hFF0000, 24'h000000, 24'h0000FF, 24'h000000};
        cap(470, 50, DONE_N, 1'b0, 0);
        cmp_model("ignore", 1, DONE_N);
        cnt = 0;
        for (int j = 1; j <= 470; j++) cnt += int'(cd[j]);
        chk("ignore_done_pulses", cnt, 1);
        cnt = 0;
        for (int j = DONE_N + 1; j <= 470; j++) cnt += int'(cb[j]);
        chk("ignore_no_refire", cnt, 0);

        cap(101, 0, 0, 1'b0, 100);
        cmp_model("pre_rst", 1, 100);
        chk("midrst_line", got(0, 101), 0);
        chk("midrst_busy", got(1, 101), 0);
        chk("midrst_done", got(2, 101), 0);
        chk("midrst_idx", got(3, 101), 0);
        cap(446, 0, 0, 1'b0, 0);
        cmp_model("post_rst", 1, 445);

        cap(2 * FL, 0, 0, 1'b1, 0);
        cmp_model("b2b", 1, 2 * FL);
        cnt = 0;
        for (int j = 1; j <= 2 * FL; j++) cnt += int'(cd[j]);
        chk("b2b_done_pulses", cnt, 2);
        chk("b2b_restart_busy", got(1, FL + 1), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
